// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    // Select for the next-PC mux.
    typedef enum logic [2:0] {
        SEQ      = 3'd0,
        HOLD     = 3'd1,
        REDIR    = 3'd2,
        TRAP     = 3'd3,
        MISALIGN = 3'd4
    } pc_cause_t;

    // True when the low log2(inc) bits of target are zero (inc is a power of two).
    function automatic logic is_aligned(input logic [63:0] target, input int unsigned inc);
        logic [63:0] mask;
        mask = 64'(inc) - 64'd1;
        return (target & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/pc_hist_buf.sv
// Ring buffer of redirect source PCs; entry 0 is the newest.
module pc_hist_buf #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [N-1:0]  push_data,
    input  logic [AW-1:0] rd_idx,
    output logic [N-1:0]  rd_data,
    output logic [AW:0]   count
);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Write pointer and saturating occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != (AW+1)'(DEPTH))
                count <= count + (AW+1)'(1);
        end
    end

    // Storage; the oldest slot is overwritten naturally once the pointer wraps.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Newest entry sits just behind the write pointer; empty slots read as zero.
    always_comb begin
        rd_ptr  = wr_ptr - AW'(1) - rd_idx;
        rd_data = '0;
        if ({1'b0, rd_idx} < count)
            rd_data = mem[rd_ptr];
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, stall, redirect, trap vectoring,
// misaligned-redirect trapping and debug halt/resume.
// Optional redirect history buffer enabled by defining PC_HIST_EN.
//
//   state | meaning
//   BOOT  | out of reset; next edge loads RESET_VECTOR and enters RUN
//   RUN   | fetching; trap > redirect > stall > sequential
//   HALT  | debug halt; pc holds except for debugger set-PC via redirect
module pc_unit import pc_pkg::*; #(
    parameter int unsigned N            = 32,
    parameter int unsigned INC          = 4,
    parameter logic [N-1:0] RESET_VECTOR = '0,
    parameter logic [N-1:0] TRAP_VECTOR  = N'(32'h0000_0100)
`ifdef PC_HIST_EN
    ,
    parameter int unsigned HIST_DEPTH   = 8
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    input  logic         trap_valid,
    input  logic         halt_req,
    input  logic         resume_req,
`ifdef PC_HIST_EN
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [N-1:0]                  hist_data,
    output logic [$clog2(HIST_DEPTH):0]   hist_count,
`endif
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus_inc,
    output logic         fetch_valid,
    output logic         misalign_err,
    output logic         halted
);

    // Reset value sits one increment below the vector so BOOT can reuse the
    // sequential path to land exactly on RESET_VECTOR.
    localparam logic [N-1:0] PC_RESET = RESET_VECTOR - N'(INC);

    pc_state_t state, state_d;
    pc_cause_t cause;
    logic [N-1:0] pc_d;

    assign pc_plus_inc = pc + N'(INC);

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= BOOT;
        else
            state <= state_d;
    end

    // Next-state logic; in HALT a simultaneous halt_req loses to resume_req.
    always_comb begin
        state_d = state;
        case (state)
            BOOT:    state_d = RUN;
            RUN:     if (halt_req) state_d = HALT;
            HALT:    if (resume_req) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Output decode from state.
    always_comb begin
        fetch_valid = (state == RUN);
        halted      = (state == HALT);
    end

    // Next-PC cause selection; redirect and trap override stall.
    always_comb begin
        cause = SEQ;
        case (state)
            RUN: begin
                if (trap_valid)
                    cause = TRAP;
                else if (redirect_valid)
                    cause = is_aligned(64'(redirect_target), INC) ? REDIR : MISALIGN;
                else if (stall)
                    cause = HOLD;
                else
                    cause = SEQ;
            end
            HALT:    cause = redirect_valid ? REDIR : HOLD;
            default: cause = SEQ;
        endcase
    end

    // Next-PC mux.
    always_comb begin
        pc_d = pc_plus_inc;
        case (cause)
            HOLD:           pc_d = pc;
            REDIR:          pc_d = redirect_target;
            TRAP, MISALIGN: pc_d = TRAP_VECTOR;
            default:        pc_d = pc_plus_inc;
        endcase
    end

    // PC register and the one-cycle misalign pulse, aligned with the trap landing.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= PC_RESET;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_d;
            misalign_err <= (cause == MISALIGN);
        end
    end

`ifdef PC_HIST_EN
    logic hist_push;

    // Record the source pc of every taken control transfer while running.
    always_comb begin
        hist_push = (state == RUN) &&
                    ((cause == TRAP) || (cause == REDIR) || (cause == MISALIGN));
    end

    pc_hist_buf #(
        .N     (N),
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk       (clk),
        .reset     (reset),
        .push      (hist_push),
        .push_data (pc),
        .rd_idx    (hist_idx),
        .rd_data   (hist_data),
        .count     (hist_count)
    );
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues the expected outputs for
// each cycle it drives; the monitor pops and compares after every rising edge.
`timescale 1ns/1ps
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        trap_valid = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume_req = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        fetch_valid;
    logic        misalign_err;
    logic        halted;
`ifdef PC_HIST_EN
    logic [2:0]  hist_idx = '0;
    logic [31:0] hist_data;
    logic [3:0]  hist_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        h;
        logic        me;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    pc_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt_req        (halt_req),
        .resume_req      (resume_req),
`ifdef PC_HIST_EN
        .hist_idx        (hist_idx),
        .hist_data       (hist_data),
        .hist_count      (hist_count),
`endif
        .pc              (pc),
        .pc_plus_inc     (pc_plus_inc),
        .fetch_valid     (fetch_valid),
        .misalign_err    (misalign_err),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rt,
                        input logic tv, input logic hr, input logic rr,
                        input logic [31:0] e_pc, input logic e_fv, input logic e_h,
                        input logic e_me, input string nm);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        trap_valid      = tv;
        halt_req        = hr;
        resume_req      = rr;
        e.pc = e_pc; e.fv = e_fv; e.h = e_h; e.me = e_me; e.name = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: compares every cycle for which an expectation is queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.name, ".pc"}, pc, e.pc);
                chk({e.name, ".pc_plus_inc"}, pc_plus_inc, e.pc + 32'd4);
                chk({e.name, ".fetch_valid"}, 32'(fetch_valid), 32'(e.fv));
                chk({e.name, ".halted"}, 32'(halted), 32'(e.h));
                chk({e.name, ".misalign_err"}, 32'(misalign_err), 32'(e.me));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //    rst st rv target        tv hr rr   exp_pc        fv h  me  name
        step(1, 0, 0, 32'h0,         0, 0, 0,  32'hFFFF_FFFC, 0, 0, 0, "reset0");
        step(1, 1, 1, 32'h40,        1, 1, 0,  32'hFFFF_FFFC, 0, 0, 0, "reset1");
        step(0, 1, 1, 32'h80,        1, 1, 0,  32'h0000_0000, 1, 0, 0, "boot");
        step(0, 0, 0, 32'h0,         0, 0, 0,  32'h0000_0004, 1, 0, 0, "seq4");
        step(0, 0, 0, 32'h0,         0, 0, 0,  32'h0000_0008, 1, 0, 0, "seq8");
        step(0, 0, 0, 32'h0,         0, 0, 0,  32'h0000_000C, 1, 0, 0, "seqC");
        step(0, 0, 0, 32'h0,         0, 0, 0,  32'h0000_0010, 1, 0, 0, "seq10");
        step(0, 1, 0, 32'h0,         0, 0, 0,  32'h0000_0010, 1, 0, 0, "stall1");
        step(0, 1, 0, 32'h0,         0, 0, 0,  32'h0000_0010, 1, 0, 0, "stall2");
        step(0, 1, 1, 32'h40,        0, 0, 0,  32'h0000_0040, 1, 0, 0, "redir_over_stall");
        step(0, 0, 1, 32'h20,        0, 0, 0,  32'h0000_0020, 1, 0, 0, "redir20");
        step(0, 0, 1, 32'h42,        0, 0, 0,  32'h0000_0100, 1, 0, 1, "misalign");
        step(0, 0, 0, 32'h0,         0, 0, 0,  32'h0000_0104, 1, 0, 0, "misalign_end");
        step(0, 0, 1, 32'h80,        1, 0, 0,  32'h0000_0100, 1, 0, 0, "trap_over_redir");
        step(0, 0, 1, 32'h30,        0, 0, 0,  32'h0000_0030, 1, 0, 0, "redir30");
        step(0, 0, 0, 32'h0,         0, 1, 0,  32'h0000_0034, 0, 1, 0, "halt");
        step(0, 1, 0, 32'h0,         1, 0, 0,  32'h0000_0034, 0, 1, 0, "halt_ignore");
        step(0, 0, 1, 32'h200,       0, 0, 0,  32'h0000_0200, 0, 1, 0, "halt_setpc");
        step(0, 0, 0, 32'h0,         0, 1, 1,  32'h0000_0200, 1, 0, 0, "resume_wins");
        step(0, 0, 0, 32'h0,         0, 0, 0,  32'h0000_0204, 1, 0, 0, "after_resume");
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0,  32'hFFFF_FFFC, 1, 0, 0, "redir_top");
        step(0, 0, 0, 32'h0,         0, 0, 0,  32'h0000_0000, 1, 0, 0, "wrap");
        step(0, 0, 0, 32'h0,         0, 1, 0,  32'h0000_0004, 0, 1, 0, "halt2");
        step(1, 0, 0, 32'h0,         0, 0, 0,  32'hFFFF_FFFC, 0, 0, 0, "reset_in_halt");
        step(0, 0, 0, 32'h0,         0, 0, 0,  32'h0000_0000, 1, 0, 0, "reboot");
        step(0, 0, 0, 32'h0,         0, 1, 0,  32'h0000_0004, 0, 1, 0, "halt3");
        step(0, 0, 1, 32'h203,       0, 0, 0,  32'h0000_0203, 0, 1, 0, "halt_setpc_unaligned");
        step(0, 0, 0, 32'h0,         0, 0, 1,  32'h0000_0203, 1, 0, 0, "resume2");
        step(0, 0, 1, 32'h300,       0, 0, 0,  32'h0000_0300, 1, 0, 0, "redir300");

`ifdef PC_HIST_EN
        step(1, 0, 0, 32'h0,         0, 0, 0,  32'hFFFF_FFFC, 0, 0, 0, "hist_reset");
        step(0, 0, 0, 32'h0,         0, 0, 0,  32'h0000_0000, 1, 0, 0, "hist_boot");
        for (int i = 0; i < 10; i++)
            step(0, 0, 1, 32'h1000 * (i + 1), 0, 0, 0, 32'h1000 * (i + 1), 1, 0, 0, "hist_redir");
`endif

        @(negedge clk);
        for (int k = 0; k < 10 && sb_q.size() > 0; k++)
            @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

`ifdef PC_HIST_EN
        chk("hist_count", 32'(hist_count), 32'd8);
        hist_idx = 3'd0;
        #1;
        chk("hist_idx0", hist_data, 32'h0000_9000);
        hist_idx = 3'd7;
        #1;
        chk("hist_idx7", hist_data, 32'h0000_2000);
        hist_idx = 3'd3;
        #1;
        chk("hist_idx3", hist_data, 32'h0000_6000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
